// File: rtl/ct_f_spsram_256x84_ctrl.sv
// 256x84 single-port SRAM controller: valid/ready requests, 1-cycle reads, response hold buffer.
// Optional power-up clear sweep enabled by defining CT_F_SPSRAM_INIT_EN.
module ct_f_spsram_256x84_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_vld,
    input  logic        req_wr,
    input  logic [7:0]  req_addr,
    input  logic [83:0] req_wdata,
    input  logic [83:0] req_wmask,
    output logic        req_rdy,
    output logic        rsp_vld,
    output logic [83:0] rsp_data,
    input  logic        rsp_rdy,
    output logic        init_done,
    output logic [7:0]  sram_a,
    output logic        sram_cen,
    output logic        sram_gwen,
    output logic [83:0] sram_wen,
    output logic [83:0] sram_d,
    input  logic [83:0] sram_q
);

    logic        run;
    logic        stall;
    logic        acc;
    logic        acc_rd;
    logic        rsp_vld_q;
    logic        hold_vld_q;
    logic [83:0] hold_q;

`ifdef CT_F_SPSRAM_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_INIT;
            cnt   <= '0;
        end else if (state == S_INIT) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'hFF) state <= S_RUN;
        end
    end

    assign run = (state == S_RUN);
`else
    assign run = 1'b1;
`endif

    // Outputs are gated by RST so the reset values hold for the whole reset cycle.
    assign stall     = rsp_vld_q & ~rsp_rdy;
    assign req_rdy   = ~RST & run & ~stall;
    assign acc       = req_vld & req_rdy;
    assign acc_rd    = acc & ~req_wr;
    assign init_done = run & ~RST;
    assign rsp_vld   = rsp_vld_q & ~RST;

    always_comb begin
        rsp_data = '0;
        if (rsp_vld) rsp_data = hold_vld_q ? hold_q : sram_q;
    end

    // First stalled cycle captures the bypass data; later cycles replay it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_vld_q  <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (acc_rd) begin
            rsp_vld_q  <= 1'b1;
            hold_vld_q <= 1'b0;
        end else if (stall) begin
            if (!hold_vld_q) begin
                hold_q     <= sram_q;
                hold_vld_q <= 1'b1;
            end
        end else begin
            rsp_vld_q  <= 1'b0;
            hold_vld_q <= 1'b0;
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
`ifdef CT_F_SPSRAM_INIT_EN
        if (!RST && !run) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt;
        end
`endif
        if (acc) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
                sram_d    = req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_256x84_ctrl.sv
// Directed bench for ct_f_spsram_256x84_ctrl with a behavioural 256x84 SRAM.
// Works with CT_F_SPSRAM_INIT_EN defined or undefined.
module tb_ct_f_spsram_256x84_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_vld;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [83:0] req_wdata;
    logic [83:0] req_wmask;
    logic        req_rdy;
    logic        rsp_vld;
    logic [83:0] rsp_data;
    logic        rsp_rdy;
    logic        init_done;
    logic [7:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [83:0] sram_wen;
    logic [83:0] sram_d;
    logic [83:0] sram_q;

    logic [83:0] mem [256];
    logic [83:0] mem_q;
    logic        frc_en;
    logic [83:0] frc_val;

    int checks = 0;
    int errors = 0;

`ifdef CT_F_SPSRAM_INIT_EN
    localparam int INIT_CYC = 256;
`else
    localparam int INIT_CYC = 0;
`endif

    localparam logic [83:0] ONES = {84{1'b1}};
    localparam logic [83:0] DAT  = 84'hA_BCDE_F012_3456_789A_BCDE;

    always #5 CLK = ~CLK;

    ct_f_spsram_256x84_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .rsp_rdy   (rsp_rdy),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                mem_q <= mem[sram_a];
        end
    end

    assign sram_q = frc_en ? frc_val : mem_q;

    function automatic logic [83:0] pat(input int a);
        return {20'hC0FFE, 8'(a), 56'h0123_4567_89AB_CD};
    endfunction

    task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        req_vld = 1'b0;
        req_wr  = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        int n;
        @(negedge CLK);
        RST     = 1'b0;
        req_vld = 1'b0;
        #1;
`ifdef CT_F_SPSRAM_INIT_EN
        chk("sweep_a0", {75'd0, sram_a, sram_cen}, {75'd0, 8'd0, 1'b0});
        chk("sweep_wr", {sram_gwen, sram_wen, sram_d}, '0);
        chk("sweep_rdy", 84'(req_rdy), 84'd0);
`endif
        n = 0;
        while (!init_done && n < 600) begin
            @(negedge CLK);
            n++;
            #1;
        end
        chk("init_lat", 84'(n), 84'(INIT_CYC));
        chk("run_rdy", 84'(req_rdy), 84'd1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [83:0] d, input logic [83:0] m);
        @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = a;
        req_wdata = d;
        req_wmask = m;
        #1;
        chk("wr_rdy", 84'(req_rdy), 84'd1);
        chk("wr_ctl", {73'd0, sram_cen, sram_gwen, sram_a}, {73'd0, 1'b0, 1'b0, a});
        chk("wr_wen", sram_wen, ~m);
        chk("wr_d", sram_d, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [83:0] exp);
        @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = a;
        rsp_rdy = 1'b1;
        #1;
        chk("rd_ctl", {72'd0, req_rdy, sram_cen, sram_gwen, rsp_vld, sram_a},
            {72'd0, 1'b1, 1'b0, 1'b1, 1'b0, a});
        chk("rd_wen", sram_wen, ONES);
        idle();
        chk("rsp_vld", 84'(rsp_vld), 84'd1);
        chk("rsp_data", rsp_data, exp);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = pat(i);
        mem_q = '0;
        frc_en = 1'b0;
        frc_val = '0;
        RST = 1'b1;
        req_vld = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_rdy = 1'b1;

        repeat (2) @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 8'h33;
        req_wdata = DAT;
        req_wmask = ONES;
        #1;
        chk("rst_out", {80'd0, req_rdy, rsp_vld, init_done, sram_cen},
            {80'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_data", rsp_data, '0);
        chk("rst_sram", {sram_gwen, sram_a, sram_d}, {1'b1, 8'd0, 84'd0});
        chk("rst_wen", sram_wen, ONES);

        release_rst();

`ifdef CT_F_SPSRAM_INIT_EN
        rd(8'h00, '0);
        rd(8'h7F, '0);
        rd(8'hFF, '0);
`else
        rd(8'h00, pat(8'h00));
        rd(8'h7F, pat(8'h7F));
        rd(8'hFF, pat(8'hFF));
`endif

        wr(8'h12, DAT, ONES);
        rd(8'h12, DAT);

        wr(8'h05, '0, ONES);
        wr(8'h05, ONES, {42'h0, 42'h3FF_FFFF_FFFF});
        rd(8'h05, {42'h0, 42'h3FF_FFFF_FFFF});

        // Stalled response with sram_q changing underneath.
        wr(8'h20, 84'h5_5AA5_1234_F00D_BEEF_CAFE, ONES);
        @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 8'h20;
        rsp_rdy = 1'b0;
        #1;
        chk("bp_acc", 84'(req_rdy), 84'd1);
        @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b1;
        req_addr = 8'h21;
        #1;
        chk("bp_c1", {rsp_vld, req_rdy, sram_cen}, {1'b1, 1'b0, 1'b1});
        chk("bp_d1", rsp_data, 84'h5_5AA5_1234_F00D_BEEF_CAFE);
        for (int c = 2; c <= 3; c++) begin
            @(negedge CLK);
            frc_en = 1'b1;
            frc_val = 84'h1_1111_2222_3333_4444_0000 + 84'(c);
            #1;
            chk("bp_ctl", {rsp_vld, req_rdy, sram_cen}, {1'b1, 1'b0, 1'b1});
            chk("bp_hold", rsp_data, 84'h5_5AA5_1234_F00D_BEEF_CAFE);
        end
        @(negedge CLK);
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        #1;
        chk("bp_rel", {rsp_vld, req_rdy}, {1'b1, 1'b1});
        chk("bp_d4", rsp_data, 84'h5_5AA5_1234_F00D_BEEF_CAFE);
        idle();
        chk("bp_done", 84'(rsp_vld), 84'd0);
        frc_en = 1'b0;

        for (int i = 1; i <= 4; i++) wr(8'(i), pat(i + 100), ONES);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            req_vld = (i <= 4);
            req_wr = 1'b0;
            req_addr = 8'(i);
            rsp_rdy = 1'b1;
            #1;
            if (i <= 4) chk("b2b_rdy", 84'(req_rdy), 84'd1);
            if (i >= 2) begin
                chk("b2b_vld", 84'(rsp_vld), 84'd1);
                chk("b2b_data", rsp_data, pat(i - 1 + 100));
            end
        end
        idle();
        chk("b2b_end", 84'(rsp_vld), 84'd0);

        // Reset while a stalled response is pending.
        @(negedge CLK);
        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 8'h12;
        rsp_rdy = 1'b0;
        @(negedge CLK);
        req_vld = 1'b0;
        RST = 1'b1;
        #1;
        chk("mrst_out", {81'd0, rsp_vld, req_rdy, sram_cen}, {81'd0, 1'b0, 1'b0, 1'b1});
        chk("mrst_data", rsp_data, '0);
        @(negedge CLK);
        release_rst();
        idle();
        chk("mrst_drop", 84'(rsp_vld), 84'd0);
        rsp_rdy = 1'b1;

`ifdef CT_F_SPSRAM_INIT_EN
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        k = 0;
        #1;
        while (sram_a != 8'd100 && k < 300) begin
            @(negedge CLK);
            k++;
            #1;
        end
        chk("sw_at100", 84'(k), 84'd100);
        RST = 1'b1;
        #1;
        chk("sw_rst_idle", {sram_cen, sram_gwen, sram_a, sram_d}, {1'b1, 1'b1, 8'd0, 84'd0});
        chk("sw_rst_wen", sram_wen, ONES);
        @(negedge CLK);
        release_rst();
        rd(8'h12, '0);
`else
        k = 0;
        rd(8'h12, DAT);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1);
    end

endmodule
